vga_sprite_engine: RTL and testbench

Parametrised VGA scan-out and sprite compositor: the successor to the fixed 8-car/1-frog display block. It generates VGA timing and composites `NUM_SPRITES` rectangular sprites, each with its own enable and 9-bit colour, over a background colour. Sprite positions are shadowed once per frame so frames never tear. A per-frame collision mask between sprite 0 (the player) and every other sprite is optional. It sits between the game-state logic and the board VGA pins.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_timing_gen.sv | 71 +++++++
 rtl/vga_sprite_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_vga_sprite_engine.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared 640x480 VGA timing defaults and rgb333 pixel format.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int C_H_ACTIVE = 640;
    localparam int C_H_FP     = 16;
    localparam int C_H_SYNC   = 96;
    localparam int C_H_BP     = 48;
    localparam int C_V_ACTIVE = 480;
    localparam int C_V_FP     = 10;
    localparam int C_V_SYNC   = 2;
    localparam int C_V_BP     = 33;

    localparam int C_H_TOTAL  = C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP;
    localparam int C_V_TOTAL  = C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP;

    localparam int C_RGB_W       = 9;
    localparam int C_RGB_FIELD_W = 3;
    localparam int C_RGB_R_LSB   = 6;
    localparam int C_RGB_G_LSB   = 3;
    localparam int C_RGB_B_LSB   = 0;

    typedef logic [C_RGB_W-1:0] rgb333_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Pixel/line counters with raw sync, active-area and frame flags.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = C_H_ACTIVE,
    parameter int H_FP     = C_H_FP,
    parameter int H_SYNC   = C_H_SYNC,
    parameter int H_BP     = C_H_BP,
    parameter int V_ACTIVE = C_V_ACTIVE,
    parameter int V_FP     = C_V_FP,
    parameter int V_SYNC   = C_V_SYNC,
    parameter int V_BP     = C_V_BP,
    parameter int H_CNT_W  = 10,
    parameter int V_CNT_W  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [H_CNT_W-1:0] o_h_cnt,
    output logic [V_CNT_W-1:0] o_v_cnt,
    output logic               o_active,
    output logic               o_hsync_raw,
    output logic               o_vsync_raw,
    output logic               o_frame_start
);

    localparam int C_HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int C_VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_CNT_W-1:0] C_H_LAST     = H_CNT_W'(C_HT - 1);
    localparam logic [H_CNT_W-1:0] C_H_ACT      = H_CNT_W'(H_ACTIVE);
    localparam logic [H_CNT_W-1:0] C_HS_START   = H_CNT_W'(H_ACTIVE + H_FP);
    localparam logic [H_CNT_W-1:0] C_HS_END     = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_CNT_W-1:0] C_V_LAST     = V_CNT_W'(C_VT - 1);
    localparam logic [V_CNT_W-1:0] C_V_ACT      = V_CNT_W'(V_ACTIVE);
    localparam logic [V_CNT_W-1:0] C_VS_START   = V_CNT_W'(V_ACTIVE + V_FP);
    localparam logic [V_CNT_W-1:0] C_VS_END     = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_CNT_W-1:0] r_h_cnt;
    logic [V_CNT_W-1:0] r_v_cnt;
    logic               w_h_last;
    logic               w_v_last;

    assign w_h_last = (r_h_cnt == C_H_LAST);
    assign w_v_last = (r_v_cnt == C_V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign o_h_cnt       = r_h_cnt;
    assign o_v_cnt       = r_v_cnt;
    assign o_active      = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
    assign o_hsync_raw   = (r_h_cnt >= C_HS_START) && (r_h_cnt < C_HS_END);
    assign o_vsync_raw   = (r_v_cnt >= C_VS_START) && (r_v_cnt < C_VS_END);
    assign o_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/vga_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module   : vga_sprite_engine
// Purpose  : VGA scan-out with NUM_SPRITES rectangular sprites over a
//            background; optional sprite-0 collision mask under the macro
//            VGA_SPRITE_COLLISION_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sprite_engine
    import vga_pkg::*;
#(
    parameter int H_ACTIVE         = C_H_ACTIVE,
    parameter int H_FP             = C_H_FP,
    parameter int H_SYNC           = C_H_SYNC,
    parameter int H_BP             = C_H_BP,
    parameter int V_ACTIVE         = C_V_ACTIVE,
    parameter int V_FP             = C_V_FP,
    parameter int V_SYNC           = C_V_SYNC,
    parameter int V_BP             = C_V_BP,
    parameter int SYNC_ACTIVE_HIGH = 1,
    parameter int NUM_SPRITES      = 8,
    parameter int SPRITE_SIZE      = 32,
    parameter int COORD_W          = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_x,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_y,
    input  logic [NUM_SPRITES-1:0]         sprite_en,
    input  logic [NUM_SPRITES*9-1:0]       sprite_rgb,
    input  logic [8:0]                     bg_rgb,
    output logic [2:0]                     red,
    output logic [2:0]                     green,
    output logic [2:0]                     blue,
    output logic                           hsync,
    output logic                           vsync,
    output logic                           frame_start,
    output logic [NUM_SPRITES-1:0]         collision_mask,
    output logic                           collision
);

    localparam int   C_HT        = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   C_VT        = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int   C_H_CNT_W   = $clog2(C_HT + 1);
    localparam int   C_V_CNT_W   = $clog2(C_VT + 1);
    localparam int   C_CNT_MAX_W = (C_H_CNT_W > C_V_CNT_W) ? C_H_CNT_W : C_V_CNT_W;
    localparam int   C_CMP_W     = ((C_CNT_MAX_W > COORD_W) ? C_CNT_MAX_W : COORD_W) + 1;
    localparam logic C_SYNC_IDLE = (SYNC_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

    logic [C_H_CNT_W-1:0] w_h_cnt;
    logic [C_V_CNT_W-1:0] w_v_cnt;
    logic                 w_active;
    logic                 w_hsync_raw;
    logic                 w_vsync_raw;
    logic                 w_frame_start;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .H_CNT_W  (C_H_CNT_W),
        .V_CNT_W  (C_V_CNT_W)
    ) u_timing (
        .clk           (clk),
        .rst_n         (rst_n),
        .o_h_cnt       (w_h_cnt),
        .o_v_cnt       (w_v_cnt),
        .o_active      (w_active),
        .o_hsync_raw   (w_hsync_raw),
        .o_vsync_raw   (w_vsync_raw),
        .o_frame_start (w_frame_start)
    );

    logic [NUM_SPRITES*COORD_W-1:0] r_sh_x;
    logic [NUM_SPRITES*COORD_W-1:0] r_sh_y;
    logic [NUM_SPRITES-1:0]         r_sh_en;
    logic [NUM_SPRITES*C_RGB_W-1:0] r_sh_rgb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_x   <= '0;
            r_sh_y   <= '0;
            r_sh_en  <= '0;
            r_sh_rgb <= '0;
        end else if (w_frame_start) begin
            r_sh_x   <= sprite_x;
            r_sh_y   <= sprite_y;
            r_sh_en  <= sprite_en;
            r_sh_rgb <= sprite_rgb;
        end
    end

    // Pixel (0,0) is tested against the values being captured, so the whole
    // frame is drawn from a single snapshot.
    logic [NUM_SPRITES*COORD_W-1:0] w_cur_x;
    logic [NUM_SPRITES*COORD_W-1:0] w_cur_y;
    logic [NUM_SPRITES-1:0]         w_cur_en;

    assign w_cur_x  = w_frame_start ? sprite_x  : r_sh_x;
    assign w_cur_y  = w_frame_start ? sprite_y  : r_sh_y;
    assign w_cur_en = w_frame_start ? sprite_en : r_sh_en;

    logic [C_CMP_W-1:0]     w_h_ext;
    logic [C_CMP_W-1:0]     w_v_ext;
    logic [NUM_SPRITES-1:0] w_hit;

    assign w_h_ext = C_CMP_W'(w_h_cnt);
    assign w_v_ext = C_CMP_W'(w_v_cnt);

    generate
        for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
            logic [C_CMP_W-1:0] w_x0;
            logic [C_CMP_W-1:0] w_y0;
            logic [C_CMP_W-1:0] w_x1;
            logic [C_CMP_W-1:0] w_y1;

            // Widened so that x + SPRITE_SIZE cannot wrap back to the left edge.
            assign w_x0 = C_CMP_W'(w_cur_x[gi*COORD_W +: COORD_W]);
            assign w_y0 = C_CMP_W'(w_cur_y[gi*COORD_W +: COORD_W]);
            assign w_x1 = w_x0 + C_CMP_W'(SPRITE_SIZE);
            assign w_y1 = w_y0 + C_CMP_W'(SPRITE_SIZE);

            assign w_hit[gi] = w_cur_en[gi]
                             && (w_h_ext >= w_x0) && (w_h_ext < w_x1)
                             && (w_v_ext >= w_y0) && (w_v_ext < w_y1);
        end
    endgenerate

    logic [NUM_SPRITES-1:0] r_s1_hit;
    logic                   r_s1_active;
    logic                   r_s1_hsync;
    logic                   r_s1_vsync;
    logic                   r_s1_fs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_hit    <= '0;
            r_s1_active <= 1'b0;
            r_s1_hsync  <= 1'b0;
            r_s1_vsync  <= 1'b0;
            r_s1_fs     <= 1'b0;
        end else begin
            r_s1_hit    <= w_hit;
            r_s1_active <= w_active;
            r_s1_hsync  <= w_hsync_raw;
            r_s1_vsync  <= w_vsync_raw;
            r_s1_fs     <= w_frame_start;
        end
    end

    rgb333_t w_pix;

    // Later iterations overwrite earlier ones: highest-index sprite on top.
    always_comb begin
        w_pix = bg_rgb;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (r_s1_hit[i]) begin
                w_pix = r_sh_rgb[i*C_RGB_W +: C_RGB_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= C_SYNC_IDLE;
            vsync       <= C_SYNC_IDLE;
            frame_start <= 1'b0;
        end else begin
            red         <= r_s1_active ? w_pix[C_RGB_R_LSB +: C_RGB_FIELD_W] : '0;
            green       <= r_s1_active ? w_pix[C_RGB_G_LSB +: C_RGB_FIELD_W] : '0;
            blue        <= r_s1_active ? w_pix[C_RGB_B_LSB +: C_RGB_FIELD_W] : '0;
            hsync       <= r_s1_hsync ^ C_SYNC_IDLE;
            vsync       <= r_s1_vsync ^ C_SYNC_IDLE;
            frame_start <= r_s1_fs;
        end
    end

`ifdef VGA_SPRITE_COLLISION_EN
    localparam logic [C_H_CNT_W-1:0] C_H_LAST = C_H_CNT_W'(C_HT - 1);
    localparam logic [C_V_CNT_W-1:0] C_V_LAST = C_V_CNT_W'(C_VT - 1);

    logic                   w_last_pixel;
    logic [NUM_SPRITES-1:0] w_overlap;
    logic [NUM_SPRITES-1:0] w_coll_next;
    logic [NUM_SPRITES-1:0] r_coll_acc;
    logic [NUM_SPRITES-1:0] r_coll_mask;
    logic                   r_coll;

    assign w_last_pixel = (w_h_cnt == C_H_LAST) && (w_v_cnt == C_V_LAST);

    always_comb begin
        w_overlap = '0;
        for (int i = 1; i < NUM_SPRITES; i++) begin
            w_overlap[i] = w_active && w_hit[0] && w_hit[i];
        end
        w_coll_next = r_coll_acc | w_overlap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coll_acc  <= '0;
            r_coll_mask <= '0;
            r_coll      <= 1'b0;
        end else if (w_last_pixel) begin
            r_coll_mask <= w_coll_next;
            r_coll      <= |w_coll_next;
            r_coll_acc  <= '0;
        end else begin
            r_coll_acc  <= w_coll_next;
        end
    end

    assign collision_mask = r_coll_mask;
    assign collision      = r_coll;
`else
    assign collision_mask = '0;
    assign collision      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sprite_engine
// Purpose  : Scoreboard bench for vga_sprite_engine on a reduced raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sprite_engine;

    localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 40, VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int NS = 8, SZ = 8, CW = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NS*CW-1:0]  sprite_x, sprite_y;
    logic [NS-1:0]     sprite_en;
    logic [NS*9-1:0]   sprite_rgb;
    logic [8:0]        bg_rgb;
    logic [2:0]        red, green, blue;
    logic              hsync, vsync, frame_start, collision;
    logic [NS-1:0]     collision_mask;

    vga_sprite_engine #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_ACTIVE_HIGH(1), .NUM_SPRITES(NS), .SPRITE_SIZE(SZ), .COORD_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_en(sprite_en),
        .sprite_rgb(sprite_rgb), .bg_rgb(bg_rgb),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
        .collision_mask(collision_mask), .collision(collision)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int sx[NS], sy[NS], srgb[NS];
    bit sen[NS];

    task automatic apply();
        for (int i = 0; i < NS; i++) begin
            sprite_x[i*CW +: CW]  = CW'(sx[i]);
            sprite_y[i*CW +: CW]  = CW'(sy[i]);
            sprite_en[i]          = sen[i];
            sprite_rgb[i*9 +: 9]  = 9'(srgb[i]);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < NS; i++) begin
            sx[i] = 0; sy[i] = 0; srgb[i] = 0; sen[i] = 1'b0;
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int h; int v; int rgb; bit hs; bit vs; bit fs; int mask;
    } exp_t;

    exp_t q[$];
    bit   model_on = 1'b0;
    int   pix = 0;
    int   fx[NS], fy[NS], frgb[NS];
    bit   fen[NS];
    int   last_mask = 0;

    function automatic bit ovl(int a, int b, int lim);
        int lo, hi;
        lo = (a > b) ? a : b;
        hi = ((a < b) ? a : b) + SZ;
        if (hi > lim) hi = lim;
        return lo < hi;
    endfunction

    function automatic int frame_mask();
        int m = 0;
`ifdef VGA_SPRITE_COLLISION_EN
        for (int i = 1; i < NS; i++)
            if (fen[0] && fen[i] && ovl(fx[0], fx[i], HA) && ovl(fy[0], fy[i], VA))
                m |= (1 << i);
`endif
        return m;
    endfunction

    always @(posedge clk) begin
        if (model_on) begin
            exp_t e;
            e.h = pix % HT;
            e.v = (pix / HT) % VT;
            e.fs = (e.h == 0) && (e.v == 0);
            e.mask = 0;
            if (e.fs) begin
                e.mask = last_mask;
                for (int i = 0; i < NS; i++) begin
                    fx[i]   = int'(sprite_x[i*CW +: CW]);
                    fy[i]   = int'(sprite_y[i*CW +: CW]);
                    fen[i]  = sprite_en[i];
                    frgb[i] = int'(sprite_rgb[i*9 +: 9]);
                end
                last_mask = frame_mask();
            end
            e.rgb = 0;
            if (e.h < HA && e.v < VA) begin
                e.rgb = int'(bg_rgb);
                for (int i = NS - 1; i >= 0; i--) begin
                    if (fen[i] && e.h >= fx[i] && e.h < fx[i] + SZ &&
                        e.v >= fy[i] && e.v < fy[i] + SZ) begin
                        e.rgb = frgb[i];
                        break;
                    end
                end
            end
            e.hs = (e.h >= HA + HFP) && (e.h < HA + HFP + HS);
            e.vs = (e.v >= VA + VFP) && (e.v < VA + VFP + VS);
            q.push_back(e);
            pix++;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (model_on && q.size() > 1) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({red, green, blue} !== 9'(e.rgb) || hsync !== e.hs ||
                vsync !== e.vs || frame_start !== e.fs) begin
                errors++;
                $display("FAIL pixel(%0d,%0d): got rgb=%o hs=%b vs=%b fs=%b, want rgb=%o hs=%b vs=%b fs=%b",
                         e.h, e.v, {red, green, blue}, hsync, vsync, frame_start,
                         9'(e.rgb), e.hs, e.vs, e.fs);
            end
            if (e.fs) begin
                checks++;
                if (collision_mask !== NS'(e.mask) || collision !== (e.mask != 0)) begin
                    errors++;
                    $display("FAIL collision: got mask=%h coll=%b, want mask=%h coll=%b",
                             collision_mask, collision, NS'(e.mask), (e.mask != 0));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_pos(int v, int h);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(((pix % HT) == h) && (((pix / HT) % VT) == v)) && guard < 2 * HT * VT);
        if (guard >= 2 * HT * VT) begin
            checks++;
            errors++;
            $display("FAIL wait_pos(%0d,%0d): position not reached, got pix=%0d", v, h, pix);
        end
    endtask

    task automatic randomize_sprites();
        for (int i = 0; i < NS; i++) begin
            sx[i]   = $urandom_range(0, HA + SZ);
            sy[i]   = $urandom_range(0, VA + SZ);
            sen[i]  = 1'($urandom_range(0, 1));
            srgb[i] = $urandom_range(0, 511);
        end
    endtask

    initial begin
        clear_all();
        sx[3] = 10; sy[3] = 5; srgb[3] = 9'o700; sen[3] = 1'b1;
        bg_rgb = 9'o007;
        apply();

        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({red, green, blue} !== 9'd0 || hsync !== 1'b0 || vsync !== 1'b0 ||
                frame_start !== 1'b0 || collision_mask !== '0 || collision !== 1'b0) begin
                errors++;
                $display("FAIL reset: got rgb=%o hs=%b vs=%b fs=%b mask=%h coll=%b, want all 0",
                         {red, green, blue}, hsync, vsync, frame_start, collision_mask, collision);
            end
        end
        rst_n = 1'b1;
        model_on = 1'b1;

        // overlap priority: sprite 5 above sprite 1
        wait_pos(VA + 2, 0);
        clear_all();
        sx[1] = 20; sy[1] = 20; srgb[1] = 9'o070; sen[1] = 1'b1;
        sx[5] = 20; sy[5] = 20; srgb[5] = 9'o707; sen[5] = 1'b1;
        apply();

        // edge clipping and far-off coordinates
        wait_pos(VA + 2, 0);
        clear_all();
        sx[6] = HA - 3; sy[6] = 10;   srgb[6] = 9'o555; sen[6] = 1'b1;
        sx[7] = 1020;   sy[7] = 12;   srgb[7] = 9'o777; sen[7] = 1'b1;
        sx[4] = 30;     sy[4] = VA - 3; srgb[4] = 9'o123; sen[4] = 1'b1;
        sx[2] = 5;      sy[2] = 1020; srgb[2] = 9'o321; sen[2] = 1'b1;
        bg_rgb = 9'o000;
        apply();

        // mid-frame update must not show until the following frame
        wait_pos(VA + 2, 0);
        wait_pos(20, 0);
        sx[6] = 0; srgb[4] = 9'o444; sen[3] = 1'b1; sx[3] = 40; sy[3] = 0; srgb[3] = 9'o246;
        apply();

        // collision between sprite 0 and sprite 2
        wait_pos(VA + 2, 0);
        clear_all();
        sx[0] = 0;  sy[0] = 0;  srgb[0] = 9'o600; sen[0] = 1'b1;
        sx[2] = 4;  sy[2] = 4;  srgb[2] = 9'o060; sen[2] = 1'b1;
        bg_rgb = 9'o111;
        apply();

        wait_pos(VA + 2, 0);
        sx[2] = 40; sy[2] = 30;
        apply();

        for (int f = 0; f < 5; f++) begin
            wait_pos(VA + 2, 0);
            randomize_sprites();
            bg_rgb = 9'($urandom_range(0, 511));
            apply();
            if (f == 2) begin
                wait_pos(VA / 2, 7);
                sx[0] = $urandom_range(0, HA);
                sx[NS-1] = $urandom_range(0, HA);
                apply();
            end
        end

        wait_pos(VA + 2, 0);
        wait_pos(2, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
